// File: rtl/mbox_req_seq_if.sv
// ---------------------------------------------------------------------------
// mbox_req_seq_if
// Bundle of the EBOX request, cache, MBOX and page-fail handshake signals
// seen by the EBOX-to-MBOX request sequencer.
//
//   master : the sequencer. It takes the start, operation, mode, cache,
//            MBOX and page-fail inputs. It drives the request, transfer,
//            completion, busy, page-fail hold, trap-force, latched public
//            mode, retry count and timeout flag.
//   slave  : the surrounding EBOX / cache / MBOX logic (the mirror image).
// ---------------------------------------------------------------------------
interface mbox_req_seq_if;
   logic       reqStart;
   logic [1:0] reqOp;
   logic       public;
   logic       user;
   logic       cshEBOXT0;
   logic       cshEBOXRetry;
   logic       mboxRespIn;
   logic       pfEBOXHandle;
   logic       pfAck;
   logic       eboxReqIn;
   logic       mboxXfer;
   logic       reqDone;
   logic       busy;
   logic       pfHold;
   logic       force1777;
   logic       ptPublic;
   logic [3:0] retryCnt;
   logic       timeoutErr;

   modport master (
      input  reqStart, reqOp, public, user, cshEBOXT0, cshEBOXRetry,
             mboxRespIn, pfEBOXHandle, pfAck,
      output eboxReqIn, mboxXfer, reqDone, busy, pfHold, force1777,
             ptPublic, retryCnt, timeoutErr
   );

   modport slave (
      output reqStart, reqOp, public, user, cshEBOXT0, cshEBOXRetry,
             mboxRespIn, pfEBOXHandle, pfAck,
      input  eboxReqIn, mboxXfer, reqDone, busy, pfHold, force1777,
             ptPublic, retryCnt, timeoutErr
   );
endinterface

// File: rtl/mbox_req_seq.sv
// ---------------------------------------------------------------------------
// mbox_req_seq
// EBOX-to-MBOX memory request sequencer (EBOX clock domain). It accepts one
// read, write or read-modify-write and runs the REQ/WAIT/XFER handshake to
// the MBOX, one phase per access (RMW = read phase then write phase). Cache
// retries go through a dead RETRY cycle. A run of RETRY_MAX retries in one
// phase, or a page fail from the EBOX, enters PFAIL. PFAIL holds the handler
// and forces trap address 1777 until pfAck.
//
// Ports:
//   eboxClk    : clock, all state changes on the rising edge
//   eboxResetN : asynchronous active-low reset
//   bus        : mbox_req_seq_if.master (start/op/mode inputs, cache and
//                MBOX handshake, page-fail in/ack, status outputs)
//
// Parameters:
//   RETRY_MAX      : retries per phase before a forced page fail (1..15)
//   TIMEOUT_CYCLES : WAIT cycles before a timeout page fail (1..255)
//
// Optional feature: define MBOX_SEQ_TIMEOUT_EN to add the WAIT timeout
// counter and the sticky timeoutErr flag. Without it, WAIT waits forever and
// timeoutErr is tied to 0.
// ---------------------------------------------------------------------------
module mbox_req_seq #(
   parameter int unsigned RETRY_MAX      = 7,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic            eboxClk,
   input logic            eboxResetN,
   mbox_req_seq_if.master bus
);

   if (RETRY_MAX < 1 || RETRY_MAX > 15) begin : g_bad_retry_max
      $error("mbox_req_seq: RETRY_MAX must be 1..15");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mbox_req_seq: TIMEOUT_CYCLES must be 1..255");
   end

   localparam logic [3:0] RETRY_LIM = 4'(RETRY_MAX);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_XFER, S_RETRY, S_PFAIL
   } state_t;

   state_t     state, state_next;
   logic [1:0] op_q;
   logic       phase_wr;        // 1 while running the write phase
   logic [3:0] retry_cnt;
   logic [3:0] retry_inc;
   logic       pt_public;
   logic       start_ok;
   logic       rmw_read;
   logic       timeout_hit;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   assign start_ok  = bus.reqStart && (bus.reqOp != 2'b00);
   assign retry_inc = sat_inc4(retry_cnt);
   // Only the read phase of an RMW chains on to another REQ.
   assign rmw_read  = (op_q == 2'b11) && !phase_wr;

   // State register
   always_ff @(posedge eboxClk or negedge eboxResetN) begin
      if (!eboxResetN) state <= S_IDLE;
      else             state <= state_next;
   end

   // Next state. REQ and WAIT resolve events in the order page fail, then
   // retry, then progress. A timeout in WAIT comes last, so a response in
   // the final allowed cycle is still accepted.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start_ok) state_next = S_REQ;
         S_REQ: begin
            if      (bus.pfEBOXHandle) state_next = S_PFAIL;
            else if (bus.cshEBOXRetry) state_next = S_RETRY;
            else if (bus.cshEBOXT0)    state_next = S_WAIT;
         end
         S_WAIT: begin
            if      (bus.pfEBOXHandle) state_next = S_PFAIL;
            else if (bus.cshEBOXRetry) state_next = S_RETRY;
            else if (bus.mboxRespIn)   state_next = S_XFER;
            else if (timeout_hit)      state_next = S_PFAIL;
         end
         S_XFER:  state_next = rmw_read ? S_REQ : S_IDLE;
         S_RETRY: state_next = (retry_inc == RETRY_LIM) ? S_PFAIL : S_REQ;
         S_PFAIL: if (bus.pfAck) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from state only.
   always_comb begin
      bus.eboxReqIn = 1'b0;
      bus.mboxXfer  = 1'b0;
      bus.reqDone   = 1'b0;
      bus.pfHold    = 1'b0;
      bus.force1777 = 1'b0;
      bus.busy      = (state != S_IDLE);
      case (state)
         S_REQ:   bus.eboxReqIn = 1'b1;
         S_XFER: begin
            bus.mboxXfer = 1'b1;
            bus.reqDone  = !rmw_read;
         end
         S_PFAIL: begin
            bus.pfHold    = 1'b1;
            bus.force1777 = 1'b1;
         end
         default: ;
      endcase
   end

   // Operation latch. It only matters outside IDLE, so it needs no reset.
   always_ff @(posedge eboxClk) begin
      if (state == S_IDLE && start_ok) op_q <= bus.reqOp;
   end

   // Phase, retry count and latched public mode.
   always_ff @(posedge eboxClk or negedge eboxResetN) begin
      if (!eboxResetN) begin
         phase_wr  <= 1'b0;
         retry_cnt <= 4'd0;
         pt_public <= 1'b0;
      end else if (state == S_IDLE && start_ok) begin
         phase_wr  <= (bus.reqOp == 2'b10);
         retry_cnt <= 4'd0;
         pt_public <= bus.public & bus.user;
      end else if (state == S_XFER && rmw_read) begin
         phase_wr  <= 1'b1;
         retry_cnt <= 4'd0;
      end else if (state == S_RETRY) begin
         retry_cnt <= retry_inc;
      end
   end

   assign bus.retryCnt = retry_cnt;
   assign bus.ptPublic = pt_public;

`ifdef MBOX_SEQ_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

   logic [7:0] wait_cnt;
   logic       timeout_err;
   logic       timeout_fire;

   // wait_cnt holds the number of WAIT cycles already spent. It is zero
   // outside WAIT, so every entry into WAIT starts from zero.
   assign timeout_hit  = (state == S_WAIT) && ((wait_cnt + 8'd1) == TO_LIM);
   assign timeout_fire = timeout_hit && !bus.pfEBOXHandle &&
                         !bus.cshEBOXRetry && !bus.mboxRespIn;

   always_ff @(posedge eboxClk or negedge eboxResetN) begin
      if (!eboxResetN) begin
         wait_cnt    <= 8'd0;
         timeout_err <= 1'b0;
      end else begin
         wait_cnt <= (state == S_WAIT) ? wait_cnt + 8'd1 : 8'd0;
         if (state == S_IDLE && start_ok) timeout_err <= 1'b0;
         else if (timeout_fire)           timeout_err <= 1'b1;
      end
   end

   assign bus.timeoutErr = timeout_err;
`else
   assign timeout_hit    = 1'b0;
   assign bus.timeoutErr = 1'b0;
`endif

endmodule
